// File: rtl/xbar_bank_adapter.sv
// xbar_bank_adapter
// Bridges one crossbar target port onto a fixed-latency memory bank and
// returns responses in acceptance order through a small credit-managed FIFO.
//
// Ports
//   clk_i, rst_ni              clock, synchronous active-low reset
//   req_valid_i / req_ready_o  request handshake from the crossbar
//   req_ini_addr_i             initiator index, echoed on the response
//   req_addr_i, req_wen_i,
//   req_be_i, req_wdata_i      request payload, forwarded to the bank
//   mem_req_o, mem_wen_o,
//   mem_addr_o, mem_be_o,
//   mem_wdata_o                bank command (combinational pass-through)
//   mem_rdata_i                bank read data, MemLatency cycles after mem_req_o
//   resp_valid_o / resp_ready_i
//                              response handshake toward the return crossbar
//   resp_ini_addr_o, resp_rdata_o
//                              response payload from the FIFO head
module xbar_bank_adapter #(
  parameter int DataWidth     = 32,
  parameter int IniAddrWidth  = 2,
  parameter int BankAddrWidth = 10,
  parameter int MemLatency    = 1,
  parameter int RespDepth     = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [IniAddrWidth-1:0]  req_ini_addr_i,
  input  logic [BankAddrWidth-1:0] req_addr_i,
  input  logic                     req_wen_i,
  input  logic [DataWidth/8-1:0]   req_be_i,
  input  logic [DataWidth-1:0]     req_wdata_i,
  output logic                     mem_req_o,
  output logic                     mem_wen_o,
  output logic [BankAddrWidth-1:0] mem_addr_o,
  output logic [DataWidth/8-1:0]   mem_be_o,
  output logic [DataWidth-1:0]     mem_wdata_o,
  input  logic [DataWidth-1:0]     mem_rdata_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [IniAddrWidth-1:0]  resp_ini_addr_o,
  output logic [DataWidth-1:0]     resp_rdata_o
);

  localparam int CreditWidth = $clog2(RespDepth + 1);
  localparam int PtrWidth    = (RespDepth > 1) ? $clog2(RespDepth) : 1;

  logic [CreditWidth-1:0]  credits_used;
  logic [CreditWidth-1:0]  fifo_count;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic [DataWidth-1:0]    push_rdata;

  logic [MemLatency-1:0]   pipe_valid;
  logic [MemLatency-1:0]   pipe_wen;
  logic [IniAddrWidth-1:0] pipe_ini [MemLatency];

  logic [DataWidth-1:0]    fifo_rdata [RespDepth];
  logic [IniAddrWidth-1:0] fifo_ini   [RespDepth];
  logic [PtrWidth-1:0]     wr_ptr;
  logic [PtrWidth-1:0]     rd_ptr;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(RespDepth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  // Ready depends only on registered credit state, so there is no
  // combinational path from req_valid_i or resp_ready_i.
  assign req_ready_o = (credits_used < CreditWidth'(RespDepth));
  assign accept      = req_valid_i && req_ready_o;

  assign mem_req_o   = accept;
  assign mem_wen_o   = req_wen_i;
  assign mem_addr_o  = req_addr_i;
  assign mem_be_o    = req_be_i;
  assign mem_wdata_o = req_wdata_i;

  assign push       = pipe_valid[MemLatency-1];
  assign push_rdata = pipe_wen[MemLatency-1] ? '0 : mem_rdata_i;

  assign resp_valid_o    = (fifo_count != '0);
  assign pop             = resp_valid_o && resp_ready_i;
  assign resp_ini_addr_o = fifo_ini[rd_ptr];
  assign resp_rdata_o    = fifo_rdata[rd_ptr];

  // Every credit covers one slot that is either in flight in the bank or
  // sitting in the FIFO, which is what keeps the FIFO from overflowing.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      credits_used <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   credits_used <= credits_used + CreditWidth'(1);
        2'b01:   credits_used <= credits_used - CreditWidth'(1);
        default: credits_used <= credits_used;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int i = 1; i < MemLatency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // Sideband of the latency pipe; meaningless unless the matching valid is set.
  always_ff @(posedge clk_i) begin
    pipe_wen[0] <= req_wen_i;
    pipe_ini[0] <= req_ini_addr_i;
    for (int i = 1; i < MemLatency; i++) begin
      pipe_wen[i] <= pipe_wen[i-1];
      pipe_ini[i] <= pipe_ini[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CreditWidth'(1);
        2'b01:   fifo_count <= fifo_count - CreditWidth'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rdata[wr_ptr] <= push_rdata;
      fifo_ini[wr_ptr]   <= pipe_ini[MemLatency-1];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(push && !pop && (fifo_count == CreditWidth'(RespDepth))))
        else $error("push into full response FIFO");
    end
  end
`endif

endmodule

// File: tb/tb_xbar_bank_adapter.sv
module tb_xbar_bank_adapter;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int AW = 10;
  localparam int ML = 1;
  localparam int D  = 3;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_ini;
  logic [AW-1:0] req_addr;
  logic          req_wen;
  logic [DW/8-1:0] req_be;
  logic [DW-1:0] req_wdata;
  logic          mem_req;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW/8-1:0] mem_be;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [IW-1:0] resp_ini;
  logic [DW-1:0] resp_rdata;

  always #5 clk = ~clk;

  xbar_bank_adapter #(
    .DataWidth(DW), .IniAddrWidth(IW), .BankAddrWidth(AW),
    .MemLatency(ML), .RespDepth(D)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_ini_addr_i(req_ini), .req_addr_i(req_addr), .req_wen_i(req_wen),
    .req_be_i(req_be), .req_wdata_i(req_wdata),
    .mem_req_o(mem_req), .mem_wen_o(mem_wen), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_ini_addr_o(resp_ini), .resp_rdata_o(resp_rdata)
  );

  typedef struct {
    logic [IW-1:0] ini;
    logic [DW-1:0] data;
    int            acc_cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            n_pass = 0;
  int            n_total = 0;
  int            cyc = 0;
  int            outstanding = 0;
  int            n_acc = 0;
  int            n_pop = 0;
  logic [DW-1:0] ref_mem [1<<AW];
  logic [DW-1:0] bank    [1<<AW];
  logic [DW-1:0] rd_pipe [ML];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, expv);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: fixed latency, byte-enabled writes, junk on the bus for writes.
  always @(posedge clk) begin
    if (mem_req && mem_wen) begin
      for (int b = 0; b < DW/8; b++)
        if (mem_be[b]) bank[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rd_pipe[0] <= (mem_req && !mem_wen) ? bank[mem_addr] : DW'($urandom);
    for (int i = 1; i < ML; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[ML-1];

  // Request-side observer: credit model, bank command, expected response.
  always @(negedge clk) begin
    logic exp_ready;
    exp_t e;
    if (rst_ni) begin
      exp_ready = (outstanding < D);
      check("req_ready", req_ready, exp_ready);
      check("mem_req", mem_req, req_valid && exp_ready);
      if (req_valid && exp_ready) begin
        check("mem_addr_wen", {mem_addr, mem_wen}, {req_addr, req_wen});
        check("mem_be_wdata", {mem_be, mem_wdata}, {req_be, req_wdata});
        e.ini = req_ini;
        e.acc_cyc = cyc;
        if (req_wen) begin
          e.data = '0;
          for (int b = 0; b < DW/8; b++)
            if (req_be[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
        end else begin
          e.data = ref_mem[req_addr];
        end
        exp_q.push_back(e);
        outstanding++;
        n_acc++;
      end
    end
  end

  // Response monitor: scoreboard pop, ordering, latency floor, hold stability.
  logic          held = 1'b0;
  logic [IW-1:0] held_ini;
  logic [DW-1:0] held_data;
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst_ni) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", resp_valid, 1'b1);
        check("hold_payload", {resp_ini, resp_rdata}, {held_ini, held_data});
      end
      if (exp_q.size() == 0) begin
        check("no_stale_resp", resp_valid, 1'b0);
      end else if (resp_valid && resp_ready) begin
        e = exp_q.pop_front();
        check("resp_ini", resp_ini, e.ini);
        check("resp_rdata", resp_rdata, e.data);
        check("resp_latency_min", (cyc - e.acc_cyc) >= ML + 1, 1'b1);
        outstanding--;
        n_pop++;
      end
      held = resp_valid && !resp_ready;
      held_ini = resp_ini;
      held_data = resp_rdata;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [IW-1:0] ini, input logic [AW-1:0] a,
                         input logic w, input logic [DW/8-1:0] be, input logic [DW-1:0] d);
    req_valid = v; req_ini = ini; req_addr = a; req_wen = w; req_be = be; req_wdata = d;
  endtask

  task automatic set_rand_req(input logic v);
    set_req(v, IW'($urandom), AW'($urandom_range(0, 15)), 1'($urandom),
            (DW/8)'($urandom), DW'($urandom));
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) next_cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  int t0, got, acc0;

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      ref_mem[i] = DW'($urandom);
      bank[i] = ref_mem[i];
    end
    ref_mem[5] = 32'hDEADBEEF;
    bank[5] = 32'hDEADBEEF;
    rst_ni = 1'b0;
    resp_ready = 1'b1;
    set_req(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (3) next_cycle();
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);

    // Single read with exact latency.
    next_cycle();
    set_req(1'b1, 2'd2, 10'h005, 1'b0, 4'hF, '0);
    @(negedge clk);
    t0 = cyc;
    next_cycle();
    req_valid = 1'b0;
    got = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = cyc - t0;
        break;
      end
    end
    check("read_latency", got, 2);
    drain();

    // Write acknowledge.
    set_req(1'b1, 2'd1, 10'h007, 1'b1, 4'hF, 32'h12345678);
    @(negedge clk);
    check("write_mem_wen", mem_wen, 1'b1);
    next_cycle();
    req_valid = 1'b0;
    drain();

    // Back-pressure: only D requests fit.
    resp_ready = 1'b0;
    acc0 = n_acc;
    for (int k = 0; k < 8; k++) begin
      set_rand_req(1'b1);
      req_wen = 1'b0;
      next_cycle();
    end
    check("bp_accepts", n_acc - acc0, D);
    @(negedge clk);
    check("bp_ready_low", req_ready, 1'b0);
    next_cycle();
    req_valid = 1'b0;
    resp_ready = 1'b1;
    drain();
    @(negedge clk);
    check("bp_ready_back", req_ready, 1'b1);
    next_cycle();

    // Throughput: 20 back-to-back requests.
    acc0 = n_acc;
    for (int k = 0; k < 20; k++) begin
      set_rand_req(1'b1);
      next_cycle();
    end
    req_valid = 1'b0;
    check("tput_accepts", n_acc - acc0, 20);
    drain();

    // Reset with two requests in flight.
    resp_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_rand_req(1'b1);
      req_wen = 1'b0;
      next_cycle();
    end
    req_valid = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk);
    exp_q.delete();
    outstanding = 0;
    next_cycle();
    rst_ni = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_resp_valid", resp_valid, 1'b0);
    check("mid_rst_req_ready", req_ready, 1'b1);
    repeat (10) next_cycle();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      set_rand_req($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      next_cycle();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    drain();
    repeat (3) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
